// File: rtl/serial_add_subtract.sv
// Digit-serial two's-complement adder/subtractor with a start/ready/valid handshake.
// Consumes DIGIT bits of each operand per clock, LSB first, and reports carry/borrow, overflow and zero.
module serial_add_subtract #(
    parameter int unsigned BITS  = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    input  logic            i_start,
    output logic            o_ready,
    input  logic [BITS-1:0] i_minuend,
    input  logic [BITS-1:0] i_subtrahend,
    input  logic            i_subtract,
    input  logic            i_signed,
    output logic [BITS-1:0] o_result,
    output logic            o_carry,
    output logic            o_overflow,
    output logic            o_zero,
    output logic            o_valid,
    output logic            o_busy
);

    localparam int unsigned STEPS = BITS / DIGIT;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (BITS % DIGIT != 0) begin : g_bad_digit
            $error("serial_add_subtract: BITS must be a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       state_q,   state_d;
    logic [BITS-1:0]  a_q,       a_d;
    logic [BITS-1:0]  b_q,       b_d;
    logic [BITS-1:0]  acc_q,     acc_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             carry_q,   carry_d;
    logic             sub_q,     sub_d;
    logic             sgn_q,     sgn_d;
    logic             a_msb_q,   a_msb_d;
    logic             bp_msb_q,  bp_msb_d;
    logic [BITS-1:0]  result_q,  result_d;
    logic             cout_q,    cout_d;
    logic             ovf_q,     ovf_d;
    logic             zero_q,    zero_d;
    logic             valid_q,   valid_d;
    logic             busy_q,    busy_d;

    logic [DIGIT:0]   digit_sum;
    logic [BITS-1:0]  acc_shift;
    logic             last_step;
    logic             cout;

    // One digit of the ripple: B is inverted for subtract, the +1 comes in through the carry.
    always_comb begin
        digit_sum = {1'b0, a_q[DIGIT-1:0]}
                  + {1'b0, b_q[DIGIT-1:0] ^ {DIGIT{sub_q}}}
                  + (DIGIT+1)'(carry_q);
        acc_shift = (acc_q >> DIGIT) | (BITS'(digit_sum[DIGIT-1:0]) << (BITS - DIGIT));
        cout      = digit_sum[DIGIT];
        last_step = (cnt_q == CNT_W'(STEPS - 1));
    end

    // Next-state and register-load decode.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        sgn_d    = sgn_q;
        a_msb_d  = a_msb_q;
        bp_msb_d = bp_msb_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    a_d      = i_minuend;
                    b_d      = i_subtrahend;
                    sub_d    = i_subtract;
                    sgn_d    = i_signed;
                    carry_d  = i_subtract;
                    cnt_d    = '0;
                    acc_d    = '0;
                    a_msb_d  = i_minuend[BITS-1];
                    bp_msb_d = i_subtrahend[BITS-1] ^ i_subtract;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_shift;
                carry_d = cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_step) begin
                    result_d = acc_shift;
                    cout_d   = cout ^ sub_q;
                    ovf_d    = sgn_q ? ((a_msb_q == bp_msb_q) && (acc_shift[BITS-1] != a_msb_q))
                                     : (cout ^ sub_q);
                    zero_d   = (acc_shift == '0);
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            sgn_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            bp_msb_q <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            sgn_q    <= sgn_d;
            a_msb_q  <= a_msb_d;
            bp_msb_q <= bp_msb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign o_ready    = (state_q == S_IDLE);
    assign o_result   = result_q;
    assign o_carry    = cout_q;
    assign o_overflow = ovf_q;
    assign o_zero     = zero_q;
    assign o_valid    = valid_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_serial_add_subtract.sv
// Scoreboard bench for serial_add_subtract: directed 16-bit vectors plus exhaustive 4-bit runs
// at DIGIT = 1, 2 and 4, with reset-abort and held-start handling.
module tb_serial_add_subtract;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 16-bit / DIGIT=4 instance
    logic        start, sub, sgn;
    logic [15:0] a, b;
    logic [15:0] res;
    logic        cy, ov, zr, valid, busy, ready;

    serial_add_subtract #(.BITS(16), .DIGIT(4)) u_dut16 (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .o_ready(ready),
        .i_minuend(a), .i_subtrahend(b), .i_subtract(sub), .i_signed(sgn),
        .o_result(res), .o_carry(cy), .o_overflow(ov), .o_zero(zr),
        .o_valid(valid), .o_busy(busy)
    );

    // 4-bit instances, index k -> DIGIT 1, 2, 4
    logic       s_start, s_sub, s_sgn;
    logic [3:0] sa, sb;
    logic [3:0] s_res   [3];
    logic       s_cy    [3];
    logic       s_ov    [3];
    logic       s_zr    [3];
    logic       s_valid [3];
    logic       s_busy  [3];
    logic       s_ready [3];

    serial_add_subtract #(.BITS(4), .DIGIT(1)) u_dut4_d1 (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(s_start), .o_ready(s_ready[0]),
        .i_minuend(sa), .i_subtrahend(sb), .i_subtract(s_sub), .i_signed(s_sgn),
        .o_result(s_res[0]), .o_carry(s_cy[0]), .o_overflow(s_ov[0]), .o_zero(s_zr[0]),
        .o_valid(s_valid[0]), .o_busy(s_busy[0])
    );
    serial_add_subtract #(.BITS(4), .DIGIT(2)) u_dut4_d2 (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(s_start), .o_ready(s_ready[1]),
        .i_minuend(sa), .i_subtrahend(sb), .i_subtract(s_sub), .i_signed(s_sgn),
        .o_result(s_res[1]), .o_carry(s_cy[1]), .o_overflow(s_ov[1]), .o_zero(s_zr[1]),
        .o_valid(s_valid[1]), .o_busy(s_busy[1])
    );
    serial_add_subtract #(.BITS(4), .DIGIT(4)) u_dut4_d4 (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(s_start), .o_ready(s_ready[2]),
        .i_minuend(sa), .i_subtrahend(sb), .i_subtract(s_sub), .i_signed(s_sgn),
        .o_result(s_res[2]), .o_carry(s_cy[2]), .o_overflow(s_ov[2]), .o_zero(s_zr[2]),
        .o_valid(s_valid[2]), .o_busy(s_busy[2])
    );

    typedef struct {
        logic [15:0] r;
        logic        c, v, z;
        int          acc;
    } exp16_t;

    typedef struct {
        logic [3:0] r;
        logic       c, v, z;
        int         acc;
    } exp4_t;

    exp16_t q16[$];
    exp4_t  q4_0[$];
    exp4_t  q4_1[$];
    exp4_t  q4_2[$];

    int vectors = 0;
    int errors  = 0;
    bit done    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever any instance presents o_valid.
    task automatic monitor();
        exp16_t e16;
        exp4_t  e4;
        bit     has;
        logic   pv16 = 1'b0;
        logic   pv4 [3] = '{1'b0, 1'b0, 1'b0};
        int     steps4 [3] = '{4, 2, 1};
        while (!done) begin
            @(negedge clk);
            if (rst_n) begin
                if (valid) begin
                    chk("valid16_single_cycle", 32'(pv16), 32'(0));
                    if (q16.size() == 0) begin
                        chk("valid16_unexpected", 32'(1), 32'(0));
                    end else begin
                        e16 = q16.pop_front();
                        chk("result16", 32'(res), 32'(e16.r));
                        chk("carry16", 32'(cy), 32'(e16.c));
                        chk("overflow16", 32'(ov), 32'(e16.v));
                        chk("zero16", 32'(zr), 32'(e16.z));
                        chk("latency16", 32'(cyc - e16.acc), 32'(4));
                        chk("ready16_in_done", 32'(ready), 32'(0));
                        chk("busy16_in_done", 32'(busy), 32'(1));
                    end
                end
                pv16 = valid;
                for (int k = 0; k < 3; k++) begin
                    if (s_valid[k]) begin
                        has = 1'b0;
                        case (k)
                            0: if (q4_0.size() != 0) begin e4 = q4_0.pop_front(); has = 1'b1; end
                            1: if (q4_1.size() != 0) begin e4 = q4_1.pop_front(); has = 1'b1; end
                            default: if (q4_2.size() != 0) begin e4 = q4_2.pop_front(); has = 1'b1; end
                        endcase
                        chk($sformatf("valid4_single_cycle[%0d]", k), 32'(pv4[k]), 32'(0));
                        if (!has) begin
                            chk($sformatf("valid4_unexpected[%0d]", k), 32'(1), 32'(0));
                        end else begin
                            chk($sformatf("result4[%0d]", k), 32'(s_res[k]), 32'(e4.r));
                            chk($sformatf("carry4[%0d]", k), 32'(s_cy[k]), 32'(e4.c));
                            chk($sformatf("overflow4[%0d]", k), 32'(s_ov[k]), 32'(e4.v));
                            chk($sformatf("zero4[%0d]", k), 32'(s_zr[k]), 32'(e4.z));
                            chk($sformatf("latency4[%0d]", k), 32'(cyc - e4.acc), 32'(steps4[k]));
                        end
                    end
                    pv4[k] = s_valid[k];
                end
            end else begin
                pv16 = 1'b0;
            end
        end
    endtask

    task automatic wait_ready16();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready16_timeout", 32'(ready), 32'(1));
    endtask

    task automatic run16(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                         input logic isgn, input logic [15:0] er, input logic ec,
                         input logic ev, input logic ez);
        exp16_t e;
        wait_ready16();
        start = 1'b1; a = ia; b = ib; sub = isub; sgn = isgn;
        @(posedge clk);
        #1;
        e.r = er; e.c = ec; e.v = ev; e.z = ez; e.acc = cyc;
        q16.push_back(e);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); sgn = 1'($urandom);
        chk("ready16_after_accept", 32'(ready), 32'(0));
    endtask

    // Independent 4-bit reference: integer arithmetic, range check for signed overflow.
    function automatic exp4_t model4(input int x, input int y, input bit isub, input bit isgn);
        exp4_t e;
        int    full, sx, sy, sr;
        full = isub ? (x - y) : (x + y);
        e.r  = 4'(full);
        e.c  = isub ? (x < y) : (full > 15);
        sx   = (x > 7) ? x - 16 : x;
        sy   = (y > 7) ? y - 16 : y;
        sr   = isub ? (sx - sy) : (sx + sy);
        e.v  = isgn ? ((sr > 7) || (sr < -8)) : e.c;
        e.z  = (e.r == 4'd0);
        e.acc = 0;
        return e;
    endfunction

    task automatic stimulus();
        int accs[$];
        int n;
        exp16_t e;
        exp4_t  m;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_result", 32'(res), 32'(0));
        chk("rst_carry", 32'(cy), 32'(0));
        chk("rst_overflow", 32'(ov), 32'(0));
        chk("rst_zero", 32'(zr), 32'(0));
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ready", 32'(ready), 32'(1));
        rst_n = 1'b1;

        // Directed 16-bit vectors: a, b, sub, signed -> result, carry, overflow, zero
        run16(16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        run16(16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b1, 1'b0);
        run16(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        run16(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run16(16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        run16(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);

        // Abort two edges into RUN: no completion, outputs cleared
        wait_ready16();
        start = 1'b1; a = 16'h00F0; b = 16'h000F; sub = 1'b0; sgn = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_result", 32'(res), 32'(0));
        chk("abort_overflow", 32'(ov), 32'(0));
        chk("abort_valid", 32'(valid), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready", 32'(ready), 32'(1));
        repeat (8) @(negedge clk);
        chk("abort_idle_ready", 32'(ready), 32'(1));
        run16(16'h00F0, 16'h000F, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0);

        // Start held high: accepts only from IDLE, every STEPS+2 cycles
        wait_ready16();
        start = 1'b1; a = 16'h0100; b = 16'h0001; sub = 1'b1; sgn = 1'b0;
        n = 0;
        while (accs.size() < 3 && n < 60) begin
            if (ready) begin
                e.r = 16'h00FF; e.c = 1'b0; e.v = 1'b0; e.z = 1'b0; e.acc = cyc + 1;
                q16.push_back(e);
                accs.push_back(cyc + 1);
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("held_start_accepts", 32'(accs.size()), 32'(3));
        if (accs.size() == 3) begin
            chk("held_start_period0", 32'(accs[1] - accs[0]), 32'(6));
            chk("held_start_period1", 32'(accs[2] - accs[1]), 32'(6));
        end

        // Exhaustive 4-bit, both modes, signed flag varied with the operands
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    n = 0;
                    @(negedge clk);
                    while (!(s_ready[0] && s_ready[1] && s_ready[2]) && n < 100) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= 100) chk("ready4_timeout", 32'(0), 32'(1));
                    s_start = 1'b1; sa = 4'(x); sb = 4'(y); s_sub = 1'(s);
                    s_sgn = 1'(x ^ (y >> 1));
                    m = model4(x, y, 1'(s), 1'(x ^ (y >> 1)));
                    @(posedge clk);
                    #1;
                    m.acc = cyc;
                    q4_0.push_back(m);
                    q4_1.push_back(m);
                    q4_2.push_back(m);
                    s_start = 1'b0;
                    sa = 4'($urandom); sb = 4'($urandom); s_sub = 1'($urandom); s_sgn = 1'($urandom);
                end
            end
        end

        // Drain the scoreboard
        n = 0;
        while ((q16.size() + q4_0.size() + q4_1.size() + q4_2.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain16", 32'(q16.size()), 32'(0));
        chk("drain4_d1", 32'(q4_0.size()), 32'(0));
        chk("drain4_d2", 32'(q4_1.size()), 32'(0));
        chk("drain4_d4", 32'(q4_2.size()), 32'(0));
        done = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0; a = '0; b = '0; sub = 1'b0; sgn = 1'b0;
        s_start = 1'b0; sa = '0; sb = '0; s_sub = 1'b0; s_sgn = 1'b0;
        fork
            monitor();
            stimulus();
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_subtract.md
Name: serial_add_subtract

Overview:
Multi-cycle, digit-serial two's-complement adder/subtractor with a start/ready/valid handshake. It processes DIGIT bits per clock, trading latency for area. It generalises the combinational subtractor with a width split, an add/subtract mode, signed/unsigned flag reporting and registered outputs. It sits beside the combinational arithmetic blocks as the low-area option for wide operands.

Parameters:
BITS, 16, operand and result width
DIGIT, 4, bits processed per clock; BITS % DIGIT != 0 is an elaboration error ($error)
STEPS, BITS/DIGIT, derived localparam; number of RUN cycles

Ports:
i_clock  input  1  clock, rising edge
i_reset_n  input  1  asynchronous, active-low reset
i_start  input  1  request; accepted only when o_ready=1
o_ready  output  1  high only in IDLE
i_minuend  input  BITS  operand A, sampled on accept
i_subtrahend  input  BITS  operand B, sampled on accept
i_subtract  input  1  1: A-B, 0: A+B; sampled on accept
i_signed  input  1  selects the o_overflow meaning; sampled on accept
o_result  output  BITS  A±B modulo 2^BITS
o_carry  output  1  add: carry-out; subtract: borrow (= inverted internal carry-out)
o_overflow  output  1  signed: two's-complement overflow; unsigned: equals o_carry
o_zero  output  1  o_result == 0
o_valid  output  1  one-cycle completion pulse
o_busy  output  1  high in RUN and DONE

Behaviour:
- One clock, i_clock. Reset is asynchronous and active-low on i_reset_n.
- Reset (i_reset_n=0, asynchronous): state IDLE; o_result, o_carry, o_overflow, o_zero, o_valid and o_busy = 0; internal shift registers, counter and carry = 0. o_ready=1, because it is decoded from IDLE.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - o_ready=1.
  - On a clock edge with i_start=1 (accept edge), capture A, B, mode and signed flag.
  - Carry init = i_subtract (add 1 for the two's complement).
  - Step counter = 0. Go to RUN.
- RUN, one digit per edge, LSB first:
  - {c, s} = A[DIGIT-1:0] + (B[DIGIT-1:0] ^ {DIGIT{sub}}) + c.
  - Shift A and B right by DIGIT.
  - Shift s into the result register from the MSB side.
  - Increment the counter.
  - After STEPS edges the full result is in place: go to DONE.
- On the final RUN edge, the output registers load together:
  - o_result: final result.
  - o_carry: c_out ^ sub.
  - o_overflow, signed: (A_msb == B'_msb) && (R_msb != A_msb), where B' = B ^ sub. Unsigned: c_out ^ sub.
  - o_zero: result == 0.
  - o_valid=1 at the same edge.
- Latency: o_valid rises exactly STEPS edges after the accept edge.
- DONE lasts one cycle: o_valid=1, o_ready=0. The next edge clears o_valid and returns to IDLE.
- Throughput: one operation per STEPS+2 cycles.
- Result outputs hold their value after o_valid falls, until the next completion or reset.
- i_start while not IDLE is ignored. No queueing, no effect on the operation in flight.
- Operand and mode inputs may change freely after the accept edge.
- DIGIT == BITS is legal: STEPS=1, o_valid one edge after accept.
- DIGIT == 1 is legal: bit-serial operation.
- Reset asserted mid-RUN or in DONE aborts immediately. No o_valid is produced; outputs return to reset values.
- Arithmetic matches the combinational subtractor exactly: for subtract, {o_carry, o_result} as signed BITS+1 equals x − y for unsigned x, y.

Test Plan:
- BITS=16, DIGIT=4, sub, unsigned, A=5, B=3 -> o_result=0x0002, o_carry=0, o_overflow=0, o_zero=0; o_valid high exactly 4 edges after accept, for one cycle; o_ready low from accept until return to IDLE.
- Same config, sub, A=3, B=5 -> o_result=0xFFFE, o_carry=1. Unsigned: o_overflow=1. Signed: o_overflow=0.
- Same config, sub, signed, A=0x8000, B=0x0001 -> o_result=0x7FFF, o_carry=0, o_overflow=1.
- Same config, add, unsigned, A=0xFFFF, B=0x0001 -> o_result=0x0000, o_carry=1, o_zero=1, o_overflow=1. Signed: o_overflow=0.
- BITS=4 with DIGIT=1, 2 and 4, exhaustive over all 256 operand pairs in both modes:
  - subtract: signed {o_carry, o_result} == x−y;
  - add: {o_carry, o_result} == x+y;
  - latency == STEPS in every case.
- Reset and busy handling:
  - Pulse i_reset_n low 2 edges into RUN (BITS=16, DIGIT=4) -> no o_valid; outputs 0; o_ready=1 after release.
  - i_start held high during RUN -> exactly one o_valid per accepted start; the next accept occurs only in IDLE.
